// File: rtl/arm_dp_pkg.sv
// Shared encodings for the ARM data-processing issue stage: ALU opcodes,
// condition codes, flag bit positions and the issued micro-op layout.
package arm_dp_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_RSC = 4'b0111;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_BIC = 4'b1110;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic        imm;
    logic [11:0] op2;
    logic        set_flags;
    logic        writes_rd;
    logic        carry_in;
  } uop_t;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluation against an NZVC flag vector.
module cond_check
  import arm_dp_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzvc,
  output logic       pass
);

  logic n, z, v, c;
  assign n = nzvc[FLAG_N];
  assign z = nzvc[FLAG_Z];
  assign v = nzvc[FLAG_V];
  assign c = nzvc[FLAG_C];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/dp_issue.sv
// ARM data-processing issue stage: classifies and condition-checks instructions,
// registers the micro-op, and owns NZVC with a one-deep flag writeback scoreboard.
module dp_issue
  import arm_dp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_opcode,
  output logic [3:0]  out_rn,
  output logic [3:0]  out_rd,
  output logic        out_imm,
  output logic [11:0] out_op2,
  output logic        out_set_flags,
  output logic        out_writes_rd,
  output logic        out_carry_in,
  input  logic        wb_valid,
  input  logic [3:0]  wb_nzvc,
  output logic [3:0]  flags,
  output logic        skipped,
  output logic        illegal
);

  logic [3:0] cond, opcode;
  logic       s_bit, cmp_class, is_dp, flag_dep, pass;
  logic       pending, stall, accept, issue;
  uop_t       uop;

  assign cond      = instr[31:28];
  assign opcode    = instr[24:21];
  assign s_bit     = instr[20];
  assign cmp_class = (opcode[3:2] == 2'b10);

  // Multiply / extra load-store share the 00 space but set bits 7 and 4 with I=0;
  // compare-class opcodes without S are the PSR transfer space.
  assign is_dp = (instr[27:26] == 2'b00)
              && !(!instr[25] && instr[7] && instr[4])
              && !(cmp_class && !s_bit);

  assign flag_dep = (cond != COND_AL)
                 || (opcode == OP_ADC) || (opcode == OP_SBC) || (opcode == OP_RSC)
                 || s_bit;

  cond_check u_cond (
    .cond (cond),
    .nzvc (flags),
    .pass (pass)
  );

  assign stall    = pending && is_dp && flag_dep;
  assign in_ready = !stall && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign issue    = accept && is_dp && pass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      uop       <= '0;
      flags     <= 4'b0000;
      pending   <= 1'b0;
      skipped   <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      skipped <= accept && is_dp && !pass;
      illegal <= accept && !is_dp;
      if (issue) begin
        out_valid     <= 1'b1;
        uop.opcode    <= opcode;
        uop.rn        <= instr[19:16];
        uop.rd        <= instr[15:12];
        uop.imm       <= instr[25];
        uop.op2       <= instr[11:0];
        uop.set_flags <= s_bit;
        uop.writes_rd <= !cmp_class;
        uop.carry_in  <= flags[FLAG_C];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (wb_valid && pending) flags <= wb_nzvc;
      // A same-cycle writeback and new S issue leaves the scoreboard occupied.
      pending <= (pending && !wb_valid) || (issue && s_bit);
    end
  end

  assign out_opcode    = uop.opcode;
  assign out_rn        = uop.rn;
  assign out_rd        = uop.rd;
  assign out_imm       = uop.imm;
  assign out_op2       = uop.op2;
  assign out_set_flags = uop.set_flags;
  assign out_writes_rd = uop.writes_rd;
  assign out_carry_in  = uop.carry_in;

endmodule

// File: doc/dp_issue.md
# dp_issue

Data-processing issue stage for the ARM core. Accepts 32-bit instruction words over a valid/ready handshake and owns the NZCV flags register. Evaluates each instruction's condition field, decodes data-processing fields into a registered micro-op for the ALU/barrel-shifter stage, and takes back the ALU's `nzvc` result to update the flags. A one-deep flag scoreboard blocks flag-dependent instructions until the outstanding flag writeback has landed.

## Interface
No parameters. Widths are fixed by the ARM encoding.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `instr` is valid.
- `in_ready` out 1: the stage accepts `instr` this cycle.
- `instr` in 32: ARM instruction word.
- `out_valid` out 1: micro-op valid.
- `out_ready` in 1: the ALU stage accepts the micro-op.
- `out_opcode` out 4: ALU opcode, from `instr[24:21]`.
- `out_rn` out 4: source register, from `instr[19:16]`.
- `out_rd` out 4: destination register, from `instr[15:12]`.
- `out_imm` out 1: the I bit, `instr[25]`.
- `out_op2` out 12: operand-2 field, `instr[11:0]`.
- `out_set_flags` out 1: S bit; the ALU stage must return `nzvc`.
- `out_writes_rd` out 1: 0 for opcodes `10xx` (TST, TEQ, CMP, CMN), else 1.
- `out_carry_in` out 1: C flag sampled at issue.
- `wb_valid` in 1: flag writeback strobe.
- `wb_nzvc` in 4: flag writeback value, bit order [3]=N, [2]=Z, [1]=V, [0]=C.
- `flags` out 4: current NZCV register, same bit order.
- `skipped` out 1: one-cycle pulse when an instruction is consumed with its condition false.
- `illegal` out 1: one-cycle pulse when an instruction is consumed that is not data-processing.

## Operation
- **Classification.** An instruction is data-processing when both hold:
  - `instr[27:26]==00` and not (`instr[25]==0 && instr[7]==1 && instr[4]==1`), which excludes multiply and extra load/store encodings;
  - not (opcode `10xx` with S==0), which excludes MRS/MSR space.
- Everything else is illegal.
- **Condition codes** (`instr[31:28]`) follow standard ARM: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL. Code `1111` (NV) always fails.
- **Flag-dependent** means any of: cond != AL; opcode is ADC, SBC or RSC; S==1.
- **Stall** condition: `pending==1` and the instruction is flag-dependent. Illegal instructions never stall.
- **`in_ready`** = !stall && (!out_valid || out_ready).
- **On acceptance** (`in_valid && in_ready`):
  - Illegal: assert `illegal` next cycle; no micro-op.
  - Condition false: assert `skipped` next cycle; no micro-op.
  - Otherwise: load the output register and set `out_valid`. If S==1, set `pending`.
- **Decisions use registered state only.** `flags` and `pending` are read as registered values; there is no bypass from `wb_*`.
- **Writeback.** `wb_valid && pending` loads `flags <= wb_nzvc` and clears `pending`. `wb_valid` while `!pending` is ignored; the verifier asserts this never happens.
- **Simultaneous writeback and issue.** `wb_valid` in the same cycle as acceptance of an S instruction: the writeback clears `pending` and the new issue sets it, so `pending` ends at 1.
- **Output hold.** While `out_valid && !out_ready`, every `out_*` field is held stable.

## Timing
- Acceptance in cycle n gives `out_valid`, `skipped` or `illegal` in cycle n+1.
- Throughput is one instruction per cycle when there is no backpressure and no stall.
- A flag-dependent instruction behind an S instruction is accepted no earlier than the cycle after `wb_valid`.
- **Reset values:**
  - `out_valid`=0, `flags`=0000, `pending`=0, `skipped`=0, `illegal`=0;
  - all `out_*` data fields = 0.
- **Reset mid-operation:** an in-flight micro-op and any pending writeback are discarded, and `in_ready` rises in the first cycle after `rst_n` deasserts.

## Structure
- Package `arm_dp_pkg` holds:
  - ALU opcode localparams (AND through MVN, 4'b0000 to 4'b1111);
  - condition-code localparams;
  - flag bit indices N=3, Z=2, V=1, C=0.
- One combinational sub-module, `cond_check`, maps (cond[3:0], nzvc[3:0]) to pass.
- Classification, the scoreboard and the output register live in `dp_issue`.

## Test plan
- **Reset default issue.** After reset, `E3B00000` (MOVS r0,#0) → `out_opcode`=1101, `out_set_flags`=1, `out_imm`=1, `out_carry_in`=0. Then `wb_nzvc`=0100 → `flags`=0100.
- **Scoreboard stall.** `E3510005` (CMP r1,#5) issued, then `00821003` (ADDEQ) presented → `in_ready`=0 until the cycle after `wb_valid` with `wb_nzvc`=0100. ADDEQ then issues with `out_rn`=2, `out_rd`=1, `out_op2`=003.
- **Condition fail.** With `flags`=0000, `00821003` → `skipped` pulse and no `out_valid`. With `F3A00001` (NV) → `skipped`.
- **Illegal encodings.** `E0000291` (MUL) → `illegal` pulse, no stall, `flags` unchanged. `E10F0000` (MRS) → `illegal`.
- **Backpressure and carry.** With `flags`=0001, issue `E0A10002` (ADC) → `out_carry_in`=1. Then hold `out_ready`=0 for 3 cycles with `in_valid`=1 → outputs stable, `in_ready`=0, and exactly one issue after release.
- **Reset mid-operation.** Pulse `rst_n` low while `out_valid`=1 and `pending`=1 → all outputs return to their reset values asynchronously; a following `wb_valid` is ignored.
